mem_port_arbiter: RTL

- Shares one unified memory port between instruction fetch (IF) and the load/store unit (LS).
- Decides who owns the port, registers the winner's request onto the port, and returns read data and a completion pulse to that requester.
- Drives the select of the 32-bit 2:1 address/data mux (0 = IF, 1 = LS).
- Sits between the fetch stage, the LSU and the memory interface.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
// Optional watchdog on stalled port accesses: define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int N = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic         clk,
    input  logic         rst,
`ifdef ARB_TIMEOUT_EN
    output logic         err,
`endif
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic [N-1:0] if_rdata,
    output logic         if_valid,
    input  logic         ls_req,
    input  logic         ls_we,
    input  logic [N-1:0] ls_addr,
    input  logic [N-1:0] ls_wdata,
    output logic [N-1:0] ls_rdata,
    output logic         ls_valid,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic         sel,
    output logic         if_stall,
    output logic         ls_stall
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t       state_q;
    logic         last_ls_q;
    logic         sel_q;
    logic         mem_req_q;
    logic         mem_we_q;
    logic [N-1:0] mem_addr_q;
    logic [N-1:0] mem_wdata_q;
    logic [N-1:0] if_rdata_q;
    logic [N-1:0] ls_rdata_q;
    logic         if_valid_q;
    logic         ls_valid_q;
    logic         grant_ls_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    assign err = err_q;
`endif

    // LS wins when it is alone, or on a tie when IF was served last.
    always_comb begin
        grant_ls_d = ls_req & (~if_req | ~last_ls_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_ls_q   <= 1'b1;
            sel_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (if_req || ls_req) begin
                        mem_req_q <= 1'b1;
                        last_ls_q <= grant_ls_d;
                        sel_q     <= grant_ls_d;
`ifdef ARB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                        if (grant_ls_d) begin
                            state_q     <= BUSY_LS;
                            mem_we_q    <= ls_we;
                            mem_addr_q  <= ls_addr;
                            mem_wdata_q <= ls_wdata;
                        end else begin
                            state_q     <= BUSY_IF;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    if (mem_ready) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (state_q == BUSY_LS) begin
                            ls_rdata_q <= mem_rdata;
                            ls_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        // Abandon the access; the requester keeps stalling and re-arbitrates.
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_valid  = if_valid_q;
    assign ls_valid  = ls_valid_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign ls_stall  = ls_req & ~ls_valid_q;

endmodule
